// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for register_file_sb.
// Contents: DEFAULT_WIDTH / DEFAULT_DEPTH parameter defaults and in_range(),
// which tells whether an address selects an existing register (DEPTH need not
// be a power of two, so some encodable addresses are unused).
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_DEPTH = 4;

    function automatic logic in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// register_file_sb_if: decoder/write-back bus of the scoreboarded register file.
// Signals: D/ENW/WRA write port, RSV/RSVA reserve port, ENR0/RDA0 and
// ENR1/RDA1 read requests, Q0/Q1 read data, BUSY0/BUSY1 pending flags of the
// addressed registers, PEND full pending vector.
// Modports: master (decoder / bus side), slave (register file side).
interface register_file_sb_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) ();

    logic [WIDTH-1:0] D;
    logic             ENW;
    logic [AW-1:0]    WRA;
    logic             RSV;
    logic [AW-1:0]    RSVA;
    logic             ENR0;
    logic             ENR1;
    logic [AW-1:0]    RDA0;
    logic [AW-1:0]    RDA1;
    logic [WIDTH-1:0] Q0;
    logic [WIDTH-1:0] Q1;
    logic             BUSY0;
    logic             BUSY1;
    logic [DEPTH-1:0] PEND;

    modport master (
        output D, ENW, WRA, RSV, RSVA, ENR0, ENR1, RDA0, RDA1,
        input  Q0, Q1, BUSY0, BUSY1, PEND
    );

    modport slave (
        input  D, ENW, WRA, RSV, RSVA, ENR0, ENR1, RDA0, RDA1,
        output Q0, Q1, BUSY0, BUSY1, PEND
    );

endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of register_file_sb.
// Ports: en_i/addr_i read request, regs_i/pend_i register and pending state,
// wr_en_i/wr_addr_i/wr_data_i current write (only with REGFILE_BYPASS_EN),
// q_o read data, busy_o pending flag of the addressed register.
// Disabled or out-of-range reads return zero data and not busy.
// REGFILE_BYPASS_EN: a same-cycle write to the addressed register is
// forwarded, and the port reports not busy because that write retires it.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] regs_i [DEPTH],
    input  logic [DEPTH-1:0] pend_i,
`ifdef REGFILE_BYPASS_EN
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
`endif
    output logic [WIDTH-1:0] q_o,
    output logic             busy_o
);

    logic hit;

    assign hit = en_i && in_range(32'(addr_i), DEPTH);

`ifdef REGFILE_BYPASS_EN
    logic fwd;

    // A reservation in the same cycle only lands after the edge, so forwarding
    // always reports not busy.
    assign fwd    = wr_en_i && in_range(32'(wr_addr_i), DEPTH) && wr_addr_i == addr_i;
    assign q_o    = !hit ? '0 : fwd ? wr_data_i : regs_i[addr_i];
    assign busy_o = hit && !fwd && pend_i[addr_i];
`else
    assign q_o    = hit ? regs_i[addr_i] : '0;
    assign busy_o = hit && pend_i[addr_i];
`endif

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: DEPTH x WIDTH register file with a pending scoreboard.
// Ports: CLKb clock (state changes on the falling edge), Resetb synchronous
// active-low reset, bus slave modport carrying the write, reserve and two
// read ports plus the PEND vector.
// A write clears the pending bit of its register; a reserve sets it, and a
// reserve wins over a write to the same register on the same edge.
// REGFILE_BYPASS_EN: enables write-through forwarding in both read ports.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic                 CLKb,
    input logic                 Resetb,
    register_file_sb_if.slave   bus
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             wr_ok;
    logic             rsv_ok;

    assign wr_ok  = bus.ENW && in_range(32'(bus.WRA), DEPTH);
    assign rsv_ok = bus.RSV && in_range(32'(bus.RSVA), DEPTH);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = (wr_ok && bus.WRA == AW'(i)) ? bus.D : regs_q[i];
            pend_d[i] = (rsv_ok && bus.RSVA == AW'(i)) || (pend_q[i] && !(wr_ok && bus.WRA == AW'(i)));
        end
    end

    always_ff @(negedge CLKb) begin
        if (!Resetb) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign bus.PEND = pend_q;

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rp0 (
        .en_i      (bus.ENR0),
        .addr_i    (bus.RDA0),
        .regs_i    (regs_q),
        .pend_i    (pend_q),
`ifdef REGFILE_BYPASS_EN
        .wr_en_i   (bus.ENW),
        .wr_addr_i (bus.WRA),
        .wr_data_i (bus.D),
`endif
        .q_o       (bus.Q0),
        .busy_o    (bus.BUSY0)
    );

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rp1 (
        .en_i      (bus.ENR1),
        .addr_i    (bus.RDA1),
        .regs_i    (regs_q),
        .pend_i    (pend_q),
`ifdef REGFILE_BYPASS_EN
        .wr_en_i   (bus.ENW),
        .wr_addr_i (bus.WRA),
        .wr_data_i (bus.D),
`endif
        .q_o       (bus.Q1),
        .busy_o    (bus.BUSY1)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: checks register_file_sb (DEPTH=5, so addresses 5..7 are
// out of range) against a register/pending-array model, with directed cases
// followed by random traffic. Honours REGFILE_BYPASS_EN in the model.
module tb_register_file_sb;

    localparam int W = 10;
    localparam int N = 5;

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    logic [W-1:0] mem [N];
    logic [N-1:0] pend_m;

    register_file_sb_if #(.WIDTH(W), .DEPTH(N)) bus ();

    register_file_sb #(.WIDTH(W), .DEPTH(N)) dut (
        .CLKb   (clk),
        .Resetb (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic fwd_hit(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        return bus.ENW && int'(bus.WRA) < N && a == bus.WRA;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] exp_q(input logic en, input logic [2:0] a);
        if (!en || int'(a) >= N) return '0;
        if (fwd_hit(a)) return bus.D;
        return mem[a];
    endfunction

    function automatic logic exp_busy(input logic en, input logic [2:0] a);
        if (!en || int'(a) >= N || fwd_hit(a)) return 1'b0;
        return pend_m[a];
    endfunction

    task automatic check_all(input string ph);
        check({ph, "_q0"},   32'(bus.Q0),    32'(exp_q(bus.ENR0, bus.RDA0)));
        check({ph, "_q1"},   32'(bus.Q1),    32'(exp_q(bus.ENR1, bus.RDA1)));
        check({ph, "_b0"},   32'(bus.BUSY0), 32'(exp_busy(bus.ENR0, bus.RDA0)));
        check({ph, "_b1"},   32'(bus.BUSY1), 32'(exp_busy(bus.ENR1, bus.RDA1)));
        check({ph, "_pend"}, 32'(bus.PEND),  32'(pend_m));
    endtask

    task automatic model_edge();
        if (!rstn) begin
            for (int i = 0; i < N; i++) mem[i] = '0;
            pend_m = '0;
        end else begin
            if (bus.ENW && int'(bus.WRA) < N) begin
                mem[bus.WRA]    = bus.D;
                pend_m[bus.WRA] = 1'b0;
            end
            if (bus.RSV && int'(bus.RSVA) < N) pend_m[bus.RSVA] = 1'b1;
        end
    endtask

    task automatic cyc(input bit pre, input logic r, input logic we, input int wa, input int dd,
                       input logic rs, input int ra, input logic e0, input int a0,
                       input logic e1, input int a1);
        @(posedge clk);
        rstn     = r;
        bus.ENW  = we;
        bus.WRA  = 3'(wa);
        bus.D    = W'(dd);
        bus.RSV  = rs;
        bus.RSVA = 3'(ra);
        bus.ENR0 = e0;
        bus.RDA0 = 3'(a0);
        bus.ENR1 = e1;
        bus.RDA1 = 3'(a1);
        #1;
        if (pre) check_all("pre");
        @(negedge clk);
        model_edge();
        #1;
        check_all("post");
    endtask

    initial begin
        rstn = 1'b0;
        bus.ENW = 0; bus.WRA = 0; bus.D = 0; bus.RSV = 0; bus.RSVA = 0;
        bus.ENR0 = 0; bus.RDA0 = 0; bus.ENR1 = 0; bus.RDA1 = 0;
        // initial reset: state unknown beforehand, so only post-edge checks
        cyc(0, 0, 0, 0, 0,     0, 0, 1, 0, 1, 4);
        check("rst_pend", 32'(bus.PEND), 32'h0);
        // preload every register and reserve some
        for (int i = 0; i < N; i++) cyc(1, 1, 1, i, 'h100 + i * 7, 1, (i + 1) % N, 1, i, 1, (i + 2) % N);
        // reset with a write and reserve presented: both discarded
        cyc(1, 0, 1, 2, 'h3C3, 1, 3, 1, 2, 1, 3);
        check("rst_q0", 32'(bus.Q0), 32'h0);
        check("rst_b1", 32'(bus.BUSY1), 32'h0);
        check("rst_pend2", 32'(bus.PEND), 32'h0);
        // write R2, read it back, then disable the port
        cyc(1, 1, 1, 2, 'h2A5, 0, 0, 1, 2, 0, 0);
        check("wr_r2", 32'(bus.Q0), 32'h2A5);
        cyc(1, 1, 0, 0, 0,     0, 0, 0, 2, 0, 0);
        check("dis_q0", 32'(bus.Q0), 32'h0);
        // reserve R1, then the producer writes it
        cyc(1, 1, 0, 0, 0,     1, 1, 0, 0, 1, 1);
        check("rsv_pend", 32'(bus.PEND), 32'h2);
        check("rsv_b1", 32'(bus.BUSY1), 32'h1);
        cyc(1, 1, 1, 1, 'h155, 0, 0, 0, 0, 1, 1);
        check("wb_pend", 32'(bus.PEND), 32'h0);
        check("wb_q1", 32'(bus.Q1), 32'h155);
        // write and reserve same register, then different registers
        cyc(1, 1, 1, 3, 'h0F0, 1, 3, 1, 3, 0, 0);
        check("wr_rsv_pend", 32'(bus.PEND), 32'h8);
        cyc(1, 1, 1, 0, 'h011, 1, 4, 1, 0, 1, 4);
        check("two_pend", 32'(bus.PEND), 32'h18);
        // reserving an already-pending register
        cyc(1, 1, 0, 0, 0,     1, 3, 1, 3, 1, 4);
        check("re_rsv_pend", 32'(bus.PEND), 32'h18);
        // out-of-range write, reserve and read
        cyc(1, 1, 1, 6, 'h1FF, 1, 7, 1, 7, 1, 5);
        check("oor_q0", 32'(bus.Q0), 32'h0);
        check("oor_b0", 32'(bus.BUSY0), 32'h0);
        // write to a pending register while both ports read it
        cyc(1, 1, 1, 1, 'h3FF, 1, 1, 1, 1, 1, 1);
        check("same_q", 32'(bus.Q0), 32'(bus.Q1));
        cyc(1, 1, 1, 3, 'h3FF, 0, 0, 1, 3, 1, 4);
        // random traffic including occasional resets
        for (int k = 0; k < 300; k++)
            cyc(1, $urandom_range(0, 19) != 0, 1'($urandom), $urandom_range(0, 7), int'($urandom),
                1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
                1'($urandom), $urandom_range(0, 7));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
